// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: instruction/flag inputs in, issue/branch/stall control out.
// The controller side is the master; decode, PC and execute logic sit on the slave side.
interface fetch_ctrl_if;
   logic              [8:0]  Instr;
   logic                     CondFlag;
   logic                     FlagValid;
   logic                     Branch;
   logic signed       [2:0]  Target;
   logic                     Stall;
   logic              [8:0]  InstrOut;
   logic                     Valid;
   logic                     Done;
   logic              [15:0] IssueCount;

   modport master (
      input  Instr, CondFlag, FlagValid,
      output Branch, Target, Stall, InstrOut, Valid, Done, IssueCount
   );

   modport slave (
      output Instr, CondFlag, FlagValid,
      input  Branch, Target, Stall, InstrOut, Valid, Done, IssueCount
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues ROM words to decode, interlocks branches on
// unresolved flags, holds the PC for loads and halts, and counts issued instructions.
module fetch_ctrl #(
   parameter int unsigned LOAD_STALL = 2,
   parameter logic [8:0]  NOP_WORD   = 9'h000
) (
   input logic          CLK,
   input logic          Init,
   fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, HALT = 2'd2} state_t;

   localparam logic [2:0] OP_BRANCH = 3'b111;
   localparam logic [2:0] OP_LOAD   = 3'b110;
   localparam logic [2:0] OP_HALT   = 3'b101;
   // The load cycle itself is the first stall cycle, so WAIT counts the remainder.
   localparam logic [2:0] LOAD_CNT  = 3'(LOAD_STALL - 1);

   state_t             state, state_n;
   logic        [2:0]  cnt, cnt_n;
   logic               done;
   logic        [15:0] issue_cnt;
   logic               branch;
   logic signed [2:0]  target;
   logic               stall;
   logic        [8:0]  instr_out;
   logic               valid;
   logic        [2:0]  op;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign op = bus.Instr[8:6];

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      branch    = 1'b0;
      target    = 3'sd0;
      stall     = 1'b0;
      instr_out = NOP_WORD;
      valid     = 1'b0;
      if (!Init) begin
         case (state)
            RUN: begin
               case (op)
                  OP_BRANCH: begin
                     if (!bus.FlagValid) begin
                        stall = 1'b1;
                     end else begin
                        valid     = 1'b1;
                        instr_out = bus.Instr;
                        if (bus.CondFlag) begin
                           branch = 1'b1;
                           target = signed'(bus.Instr[2:0]);
                        end
                     end
                  end
                  OP_LOAD: begin
                     valid     = 1'b1;
                     instr_out = bus.Instr;
                     stall     = 1'b1;
                     cnt_n     = LOAD_CNT;
                     state_n   = WAIT;
                  end
                  OP_HALT: begin
                     valid     = 1'b1;
                     instr_out = bus.Instr;
                     stall     = 1'b1;
                     state_n   = HALT;
                  end
                  default: begin
                     valid     = 1'b1;
                     instr_out = bus.Instr;
                  end
               endcase
            end
            WAIT: begin
               if (cnt != 3'd0) begin
                  stall = 1'b1;
                  cnt_n = cnt - 3'd1;
               end else begin
                  state_n = RUN;
               end
            end
            HALT: begin
               stall = 1'b1;
            end
            default: begin
               state_n = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Init) begin
         state     <= RUN;
         cnt       <= 3'd0;
         done      <= 1'b0;
         issue_cnt <= 16'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state_n == HALT) begin
            done <= 1'b1;
         end
         if (valid) begin
            issue_cnt <= sat_inc(issue_cnt);
         end
      end
   end

   assign bus.Branch     = branch;
   assign bus.Target     = target;
   assign bus.Stall      = stall;
   assign bus.InstrOut   = instr_out;
   assign bus.Valid      = valid;
   assign bus.Done       = done;
   assign bus.IssueCount = issue_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vectors with literal checks, plus a per-cycle
// comparison against a behavioural model of issue/stall/halt rules.
module tb_fetch_ctrl;
   localparam int LS = 3;

   logic CLK;
   logic Init;
   int   tests;
   int   fails;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.LOAD_STALL(LS), .NOP_WORD(9'h000)) dut (
      .CLK  (CLK),
      .Init (Init),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_busy is the number of cycles still owed to an outstanding load.
   bit         m_ok;
   bit         m_halt, n_halt;
   int         m_busy, n_busy;
   bit         m_done, n_done;
   int         m_cnt,  n_cnt;

   always @(negedge CLK) begin
      bit         eb, es, ev;
      logic [2:0] et;
      logic [8:0] eo;
      logic [2:0] tt;
      eb = 0; es = 0; ev = 0; et = 3'd0; eo = 9'h000;
      n_halt = m_halt; n_busy = m_busy; n_done = m_done; n_cnt = m_cnt;
      if (m_ok && !Init) begin
         if (m_halt) begin
            es = 1;
         end else if (m_busy > 0) begin
            es = (m_busy > 1);
            n_busy = m_busy - 1;
         end else begin
            case (bus.Instr[8:6])
               3'b111: begin
                  if (!bus.FlagValid) es = 1;
                  else begin
                     ev = 1; eo = bus.Instr;
                     if (bus.CondFlag) begin eb = 1; et = bus.Instr[2:0]; end
                  end
               end
               3'b110: begin ev = 1; eo = bus.Instr; es = 1; n_busy = LS; end
               3'b101: begin ev = 1; eo = bus.Instr; es = 1; n_halt = 1; n_done = 1; end
               default: begin ev = 1; eo = bus.Instr; end
            endcase
         end
         if (ev && m_cnt < 65535) n_cnt = m_cnt + 1;
         tt = bus.Target;
         chk("m_branch",   int'(bus.Branch),   int'(eb));
         chk("m_target",   int'(tt),           int'(et));
         chk("m_stall",    int'(bus.Stall),    int'(es));
         chk("m_valid",    int'(bus.Valid),    int'(ev));
         chk("m_instrout", int'(bus.InstrOut), int'(eo));
         chk("m_done",     int'(bus.Done),     int'(m_done));
         chk("m_count",    int'(bus.IssueCount), m_cnt);
         chk("m_no_br_stall", int'(bus.Branch && bus.Stall), 0);
      end else if (m_ok && Init) begin
         chk("m_init_branch", int'(bus.Branch), 0);
         chk("m_init_stall",  int'(bus.Stall),  0);
         chk("m_init_valid",  int'(bus.Valid),  0);
      end
   end

   always @(posedge CLK) begin
      if (Init) begin
         m_ok = 1; m_halt = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      end else if (m_ok) begin
         m_halt = n_halt; m_busy = n_busy; m_done = n_done; m_cnt = n_cnt;
      end
   end

   task automatic drive(input bit init, input logic [8:0] ins, input bit fv, input bit cf);
      Init = init; bus.Instr = ins; bus.FlagValid = fv; bus.CondFlag = cf;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [2:0] t;
      tests = 0; fails = 0;
      m_ok = 0; m_halt = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      drive(1, 9'h041, 0, 0);
      tick(); tick();
      chk("reset_done",  int'(bus.Done), 0);
      chk("reset_count", int'(bus.IssueCount), 0);
      chk("reset_valid", int'(bus.Valid), 0);

      // Plain stream.
      for (int i = 0; i < 4; i++) begin
         drive(0, 9'h041, 0, 0);
         chk("plain_valid", int'(bus.Valid), 1);
         chk("plain_stall", int'(bus.Stall), 0);
         tick();
      end
      chk("plain_count", int'(bus.IssueCount), 4);

      // Taken branch.
      drive(0, 9'h1C6, 1, 1);
      t = bus.Target;
      chk("br_branch", int'(bus.Branch), 1);
      chk("br_target", int'(t), 6);
      chk("br_stall",  int'(bus.Stall), 0);
      tick();
      chk("br_count", int'(bus.IssueCount), 5);

      // Interlock then not-taken.
      for (int i = 0; i < 2; i++) begin
         drive(0, 9'h1C6, 0, 1);
         chk("ilk_stall", int'(bus.Stall), 1);
         chk("ilk_valid", int'(bus.Valid), 0);
         tick();
      end
      drive(0, 9'h1C6, 1, 0);
      chk("ilk_valid_after",  int'(bus.Valid), 1);
      chk("ilk_branch_after", int'(bus.Branch), 0);
      tick();
      chk("ilk_count", int'(bus.IssueCount), 6);

      // Load with LOAD_STALL=3.
      drive(0, 9'h180, 0, 0);
      chk("ld0_valid", int'(bus.Valid), 1);
      chk("ld0_stall", int'(bus.Stall), 1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(0, 9'h041, 0, 0);
         chk("ldw_stall", int'(bus.Stall), 1);
         chk("ldw_valid", int'(bus.Valid), 0);
         tick();
      end
      drive(0, 9'h041, 0, 0);
      chk("ld_adv_stall", int'(bus.Stall), 0);
      chk("ld_adv_valid", int'(bus.Valid), 0);
      tick();
      drive(0, 9'h041, 0, 0);
      chk("ld_next_valid", int'(bus.Valid), 1);
      tick();
      chk("ld_count", int'(bus.IssueCount), 8);

      // Init while WAIT has cnt=1.
      drive(0, 9'h180, 0, 0);
      tick();
      drive(0, 9'h041, 0, 0);
      tick();
      drive(1, 9'h041, 0, 0);
      chk("init_wait_stall", int'(bus.Stall), 0);
      tick();
      drive(0, 9'h0C3, 0, 0);
      chk("post_init_stall", int'(bus.Stall), 0);
      chk("post_init_valid", int'(bus.Valid), 1);
      chk("post_init_instr", int'(bus.InstrOut), 9'h0C3);
      tick();
      chk("post_init_count", int'(bus.IssueCount), 1);

      // Halt, then recover with Init.
      drive(0, 9'h140, 0, 0);
      chk("halt_valid", int'(bus.Valid), 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, (i == 1) ? 9'h180 : 9'h041, 1, 1);
         chk("halt_done",  int'(bus.Done), 1);
         chk("halt_stall", int'(bus.Stall), 1);
         chk("halt_valid_off", int'(bus.Valid), 0);
         tick();
      end
      drive(1, 9'h041, 0, 0);
      tick();
      drive(0, 9'h041, 0, 0);
      chk("rec_done",  int'(bus.Done), 0);
      chk("rec_count", int'(bus.IssueCount), 0);
      chk("rec_valid", int'(bus.Valid), 1);
      tick();

      // Self-loop branch target.
      drive(0, 9'h1C0, 1, 1);
      t = bus.Target;
      chk("self_branch", int'(bus.Branch), 1);
      chk("self_target", int'(t), 0);
      tick();

      // Mixed stream, checked by the model only (halt excluded to keep it running).
      for (int i = 0; i < 40; i++) begin
         logic [8:0] w;
         w = 9'($urandom);
         if (w[8:6] == 3'b101) w[8:6] = 3'b011;
         drive(0, w, 1'($urandom), 1'($urandom));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 2, the number of cycles a load holds the PC (legal 1..7).
REQ-002 SHALL have parameter NOP_WORD, default 9'h000, the word driven on InstrOut when nothing is issued.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Init, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Instr, input, 9 bits: the instruction at the current PC, from combinational instruction ROM.
REQ-006 SHALL have port CondFlag, input, 1 bit: branch condition from execute.
REQ-007 SHALL have port FlagValid, input, 1 bit: CondFlag is final (no flag-setting op in flight).
REQ-008 SHALL have port Branch, output, 1 bit: the PC takes the relative jump this cycle.
REQ-009 SHALL have port Target, output, 3 bits: signed branch field, scaled by 4 downstream.
REQ-010 SHALL have port Stall, output, 1 bit: the PC holds this cycle.
REQ-011 SHALL have port InstrOut, output, 9 bits: the instruction issued to decode.
REQ-012 SHALL have port Valid, output, 1 bit: InstrOut is a real issue this cycle.
REQ-013 SHALL have port Done, output, 1 bit: the program has halted.
REQ-014 SHALL have port IssueCount, output, 16 bits: count of issued instructions.

Function
REQ-015 SHALL decode opcode Instr[8:6] as follows: 3'b111 is a conditional branch with Target=Instr[2:0]; 3'b110 is a load; 3'b101 is halt; all other opcodes are plain.
REQ-016 SHALL implement states RUN, WAIT and HALT, with a 3-bit stall counter cnt.
REQ-017 SHALL make Branch, Target, Stall, InstrOut and Valid combinational functions of the state, cnt and inputs; state, cnt, Done and IssueCount SHALL be registered.
REQ-018 SHALL, when an output is not specified below, drive Branch=0, Target=0, Stall=0, Valid=0 and InstrOut=NOP_WORD.
REQ-019 SHALL, in RUN with a plain opcode: drive Valid=1, InstrOut=Instr, Stall=0; remain in RUN.
REQ-020 SHALL, in RUN with a branch and FlagValid=0: drive Stall=1, Valid=0; remain in RUN (interlock, the branch is re-evaluated next cycle).
REQ-021 SHALL, in RUN with a branch, FlagValid=1 and CondFlag=1: drive Valid=1, InstrOut=Instr, Branch=1, Target=Instr[2:0], Stall=0; remain in RUN.
REQ-022 SHALL, in RUN with a branch, FlagValid=1 and CondFlag=0: behave as a plain opcode (Branch=0, the PC increments).
REQ-023 SHALL, in RUN with a load: drive Valid=1, InstrOut=Instr, Stall=1; load cnt with LOAD_STALL-1; go to WAIT.
REQ-024 SHALL, in WAIT with cnt!=0: drive Stall=1, Valid=0; decrement cnt; ignore Instr.
REQ-025 SHALL, in WAIT with cnt==0: drive Stall=0, Valid=0; go to RUN.
REQ-026 SHALL give every load a total of LOAD_STALL Stall-high cycles followed by one PC-advance cycle.
REQ-027 SHALL, in RUN with a halt: drive Valid=1, InstrOut=Instr, Stall=1; go to HALT.
REQ-028 SHALL, in HALT: drive Stall=1, Valid=0, Done=1; remain in HALT until Init.
REQ-029 SHALL never assert Branch and Stall in the same cycle.
REQ-030 SHALL increment IssueCount on every rising edge where Valid=1, saturating at 16'hFFFF.
REQ-031 SHALL apply no special handling to Target=3'b000 (a self-loop is legal).

Reset
REQ-032 SHALL give Init priority over all other inputs and all state.
REQ-033 SHALL, on an edge with Init=1, set state=RUN, cnt=0, Done=0 and IssueCount=0.
REQ-034 SHALL, in any cycle with Init=1, force Branch=0, Stall=0 and Valid=0 combinationally.
REQ-035 SHALL return to RUN on Init asserted mid-WAIT or in HALT, with no residual Stall on the following cycle.

Verification
REQ-036 SHALL be verified with a plain stream: Instr=9'h041 for 4 cycles -> Valid=1 every cycle, Stall=0, IssueCount=4.
REQ-037 SHALL be verified with a taken branch: Instr=9'h1C6, FlagValid=1, CondFlag=1 -> Branch=1, Target=3'b110, Stall=0 in that cycle, IssueCount+1.
REQ-038 SHALL be verified with an interlock: a branch with FlagValid=0 for 2 cycles, then FlagValid=1, CondFlag=0 -> Stall=1, Valid=0 for 2 cycles, then Valid=1, Branch=0.
REQ-039 SHALL be verified with a load at LOAD_STALL=3: Instr=9'h180 -> Stall=1 for 3 cycles (Valid=1 only in the first), then Stall=0, then the next instruction issues.
REQ-040 SHALL be verified with a halt: Instr=9'h140 -> Valid=1 once, then Done=1 and Stall=1 indefinitely; Init=1 for 1 cycle -> Done=0, IssueCount=0, state RUN.
REQ-041 SHALL be verified with Init mid-WAIT (cnt=1) -> the next cycle is in RUN with Stall=0, and the instruction at the new PC issues.
